// File: rtl/seq_divider.sv
// Sequential signed divider: 16-bit dividend / 8-bit divisor, one quotient bit per
// cycle. Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor to a 1-cycle result.
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic [7:0]  Quotient,
  output logic [7:0]  Remainder,
  output logic        ready,
  output logic        overflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t      state;
  logic [15:0] dvd;     // |A| shifting out MSB-first, quotient bits shifting in
  logic [7:0]  bmag;
  logic [7:0]  pr;      // always < |B| <= 128 between iterations, so 8 bits hold it
  logic [3:0]  cnt;
  logic        sign_q, sign_r;

  logic [15:0] a_mag;
  logic [7:0]  b_mag;
  logic [8:0]  pr_sh, pr_sub;
  logic        pr_ge;
  logic        ovf;
  logic [7:0]  q_neg, r_neg;

  always_comb begin
    a_mag  = A[15] ? (~A + 16'd1) : A;
    b_mag  = B[7]  ? (~B + 8'd1)  : B;
    pr_sh  = {pr, dvd[15]};
    pr_ge  = (pr_sh >= {1'b0, bmag});
    pr_sub = pr_sh - {1'b0, bmag};
    // negative results may reach -128, i.e. magnitude 128
    ovf    = sign_q ? (dvd > 16'd128) : (dvd > 16'd127);
    q_neg  = ~dvd[7:0] + 8'd1;
    r_neg  = ~pr + 8'd1;
  end

`ifdef DIV_ZERO_DETECT_EN
  logic zdiv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; dvd <= '0; bmag <= '0; pr <= '0; cnt <= '0;
      sign_q <= 1'b0; sign_r <= 1'b0; zdiv <= 1'b0;
      Quotient <= '0; Remainder <= '0; overflow <= 1'b0; div_by_zero <= 1'b0;
      ready <= 1'b1;
    end else if (start) begin
      dvd    <= a_mag;
      bmag   <= b_mag;
      pr     <= '0;
      cnt    <= '0;
      sign_q <= A[15] ^ B[7];
      sign_r <= A[15];
      zdiv   <= (B == 8'd0);
      ready  <= 1'b0;
      state  <= (B == 8'd0) ? FIX : DIV;
    end else begin
      case (state)
        DIV: begin
          pr  <= pr_ge ? pr_sub[7:0] : pr_sh[7:0];
          dvd <= {dvd[14:0], pr_ge};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= FIX;
        end
        FIX: begin
          if (zdiv) begin
            Quotient    <= sign_r ? 8'h80 : 8'h7F;
            Remainder   <= 8'h00;
            overflow    <= 1'b1;
            div_by_zero <= 1'b1;
          end else if (ovf) begin
            Quotient    <= sign_q ? 8'h80 : 8'h7F;
            Remainder   <= 8'h00;
            overflow    <= 1'b1;
            div_by_zero <= 1'b0;
          end else begin
            Quotient    <= sign_q ? q_neg : dvd[7:0];
            Remainder   <= sign_r ? r_neg : pr;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
          end
          ready <= 1'b1;
          state <= DONE;
        end
        default: ;
      endcase
    end
  end
`else
  assign div_by_zero = 1'b0;

  // B == 0 needs no special path: every trial subtract succeeds, Uq = 16'hFFFF
  // overflows, and sign_q = A[15] picks the saturation direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; dvd <= '0; bmag <= '0; pr <= '0; cnt <= '0;
      sign_q <= 1'b0; sign_r <= 1'b0;
      Quotient <= '0; Remainder <= '0; overflow <= 1'b0;
      ready <= 1'b1;
    end else if (start) begin
      dvd    <= a_mag;
      bmag   <= b_mag;
      pr     <= '0;
      cnt    <= '0;
      sign_q <= A[15] ^ B[7];
      sign_r <= A[15];
      ready  <= 1'b0;
      state  <= DIV;
    end else begin
      case (state)
        DIV: begin
          pr  <= pr_ge ? pr_sub[7:0] : pr_sh[7:0];
          dvd <= {dvd[14:0], pr_ge};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= FIX;
        end
        FIX: begin
          if (ovf) begin
            Quotient  <= sign_q ? 8'h80 : 8'h7F;
            Remainder <= 8'h00;
            overflow  <= 1'b1;
          end else begin
            Quotient  <= sign_q ? q_neg : dvd[7:0];
            Remainder <= sign_r ? r_neg : pr;
            overflow  <= 1'b0;
          end
          ready <= 1'b1;
          state <= DONE;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: integer-arithmetic reference with a latency countdown,
// checked every cycle, plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_seq_divider;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [7:0]  B = '0;
  logic [7:0]  Quotient, Remainder;
  logic        ready, overflow, div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Quotient(Quotient), .Remainder(Remainder), .ready(ready),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: signed integer divide, then saturate; output appears after a latency
  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       ov;
    logic       dz;
  } res_t;

  function automatic res_t ref_div(input logic [15:0] a16, input logic [7:0] b8);
    res_t res;
    int a, b, qi, ri;
    a = int'($signed(a16));
    b = int'($signed(b8));
    res = '0;
    if (b == 0) begin
      res.q  = (a < 0) ? 8'h80 : 8'h7F;
      res.ov = 1'b1;
      res.dz = DZ;
    end else begin
      qi = a / b;
      ri = a % b;
      if (qi > 127 || qi < -128) begin
        res.q  = (qi < 0) ? 8'h80 : 8'h7F;
        res.ov = 1'b1;
      end else begin
        res.q = 8'(qi);
        res.r = 8'(ri);
      end
    end
    return res;
  endfunction

  int   m_cnt = 0;
  res_t m_out = '0;
  res_t m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_out <= '0;
    end else if (start) begin
      m_cnt  <= (DZ && B == 8'd0) ? 1 : 17;
      m_pend <= ref_div(A, B);
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_out <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ({ready, Quotient, Remainder, overflow, div_by_zero} !==
          {(m_cnt == 0), m_out.q, m_out.r, m_out.ov, m_out.dz}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got rdy=%b q=%h r=%h ov=%b dz=%b want rdy=%b q=%h r=%h ov=%b dz=%b",
                 $time, ready, Quotient, Remainder, overflow, div_by_zero,
                 (m_cnt == 0), m_out.q, m_out.r, m_out.ov, m_out.dz);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Count negedges with ready low; bounded so a stuck DUT still reaches the summary
  task automatic wait_ready(output int low);
    low = 0;
    while (!ready && low < 200) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic kick(input int a, input int b);
    @(negedge clk);
    A = 16'(a); B = 8'(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_op(input string name, input int a, input int b,
                       input int eq, input int er, input int eov, input int edz,
                       input int elow);
    int low;
    kick(a, b);
    wait_ready(low);
    chk({name, "_low"}, low, elow);
    chk({name, "_q"},   int'(Quotient), eq);
    chk({name, "_r"},   int'(Remainder), er);
    chk({name, "_ov"},  int'(overflow), eov);
    chk({name, "_dz"},  int'(div_by_zero), edz);
  endtask

  initial begin
    int low;
    #1 rst = 1'b1;
    #20;
    chk("rst_ready", int'(ready), 1);
    chk("rst_q", int'(Quotient), 0);
    chk("rst_r", int'(Remainder), 0);
    chk("rst_ov", int'(overflow), 0);
    @(negedge clk) rst = 1'b0;

    do_op("p_p",      100,    7,   14,    2,    0, 0, 17);
    do_op("n_p",     -100,    7,   8'hF2, 8'hFE, 0, 0, 17);
    do_op("p_n",      100,   -7,   8'hF2, 8'h02, 0, 0, 17);
    do_op("min_q",  -16256, 127,   8'h80, 0,    0, 0, 17);
    do_op("ovf_pos",  1000,   3,   8'h7F, 0,    1, 0, 17);
    do_op("ovf_min", -32768, -128, 8'h7F, 0,    1, 0, 17);
    do_op("div0",       -5,   0,   8'h80, 0,    1, int'(DZ), DZ ? 1 : 17);
    do_op("clr_dz",      7,   3,   2,     1,    0, 0, 17);
    do_op("div0_pos",   42,   0,   8'h7F, 0,    1, int'(DZ), DZ ? 1 : 17);
    do_op("exact",    -128,   1,   8'h80, 0,    0, 0, 17);

    // Abort: restart at cycle 8 of a division
    kick(100, 7);
    repeat (6) @(negedge clk);
    A = 16'd50; B = 8'd5; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_ready(low);
    chk("abort_low", low, 17);
    chk("abort_q", int'(Quotient), 10);
    chk("abort_r", int'(Remainder), 0);

    // Reset at cycle 9 of a division
    kick(100, 7);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_ready", int'(ready), 1);
    chk("mrst_q", int'(Quotient), 0);
    chk("mrst_r", int'(Remainder), 0);
    chk("mrst_ov", int'(overflow), 0);
    @(negedge clk) rst = 1'b0;
    do_op("after_rst", 9, 2, 4, 1, 0, 0, 17);

    // Held start keeps ready low; result comes 17 cycles after release
    @(negedge clk);
    A = 16'd9; B = 8'd2; start = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_ready", int'(ready), 0);
    A = -16'sd9; B = 8'd2;
    @(negedge clk) start = 1'b0;
    wait_ready(low);
    chk("held_low", low, 17);
    chk("held_q", int'(Quotient), 8'hFC);
    chk("held_r", int'(Remainder), 8'hFF);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
